// File: rtl/exec_ctrl.sv
// Run controller for the single-cycle core: decides each cycle whether the
// datapath may commit PC/Regs/CC/Mem, and supports run, pause, single-step,
// a hardware breakpoint and a terminal fault stop.
module exec_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       stat,
    input  logic [63:0]      PCaddress,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [63:0]      bp_addr,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;

    state_t     state_q, state_d;
    logic [2:0] cause_q, cause_d;
    logic       resume_q, resume_d;
    logic       cpu_en_c;
    logic       fault;
    logic       bp_hit;
    logic [2:0] fault_cause;

    assign fault  = (stat != STAT_AOK);
    // resume masks the breakpoint so a run restarted on bp_addr executes it
    assign bp_hit = bp_en && (PCaddress == bp_addr) && !resume_q;

    // Map the non-AOK status code onto its stop reason
    always_comb begin
        case (stat)
            3'd2:    fault_cause = 3'd4;
            3'd3:    fault_cause = 3'd5;
            3'd4:    fault_cause = 3'd6;
            default: fault_cause = 3'd7;
        endcase
    end

    // Next-state, stop cause, resume flag and commit enable
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        resume_d = resume_q;
        cpu_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_req) begin
                    state_d  = RUN;
                    cause_d  = 3'd0;
                    resume_d = 1'b1;
                end else if (step_req) begin
                    state_d = STEP;
                    cause_d = 3'd0;
                end
            end
            RUN: begin
                // any exit from RUN or any commit in RUN drops the resume mask
                resume_d = 1'b0;
                if (fault) begin
                    state_d = FAULT;
                    cause_d = fault_cause;
                end else if (halt_req) begin
                    state_d = IDLE;
                    cause_d = 3'd1;
                end else if (bp_hit) begin
                    state_d = IDLE;
                    cause_d = 3'd2;
                end else begin
                    cpu_en_c = 1'b1;
                end
            end
            STEP: begin
                if (fault) begin
                    state_d = FAULT;
                    cause_d = fault_cause;
                end else begin
                    cpu_en_c = 1'b1;
                    state_d  = IDLE;
                    cause_d  = 3'd3;
                end
            end
            default: ;  // FAULT is terminal until reset
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cause_q  <= 3'd0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            resume_q <= resume_d;
        end
    end

    // Activity counters; both wrap naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q == RUN || state_q == STEP) cycle_cnt <= cycle_cnt + 1'b1;
            if (cpu_en_c) instr_cnt <= instr_cnt + 1'b1;
        end
    end

    assign cpu_en     = cpu_en_c;
    assign state      = state_q;
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl, built with 4-bit counters so wrap is reachable.
module tb_exec_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       stat = 3'd1;
    logic [63:0]      PCaddress = '0;
    logic             run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
    logic             bp_en = 1'b0;
    logic [63:0]      bp_addr = '0;
    logic             cpu_en;
    logic [1:0]       state;
    logic [2:0]       halt_cause;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    exec_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stat(stat), .PCaddress(PCaddress),
        .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .cpu_en(cpu_en), .state(state),
        .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance past one rising edge; inputs are then changed mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_run();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
    endtask

    logic [2:0] f_stat [4] = '{3'd2, 3'd3, 3'd4, 3'd0};
    logic [2:0] f_exp  [4] = '{3'd4, 3'd5, 3'd6, 3'd7};

    initial begin
        // reset state
        do_reset(); settle();
        chk("rst_state", state, 0);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cyc", cycle_cnt, 0);
        chk("rst_ins", instr_cnt, 0);

        // halt_req in IDLE does nothing
        halt_req = 1'b1; tick(); halt_req = 1'b0; settle();
        chk("idle_halt_state", state, 0);

        // reset mid-RUN
        start_run(); settle();
        chk("run_state", state, 1);
        chk("run_cpu_en", cpu_en, 1);
        repeat (10) tick();
        chk("run10_ins", instr_cnt, 10);
        chk("run10_cyc", cycle_cnt, 10);
        do_reset(); settle();
        chk("midrun_rst_state", state, 0);
        chk("midrun_rst_cpu_en", cpu_en, 0);
        chk("midrun_rst_ins", instr_cnt, 0);
        chk("midrun_rst_cyc", cycle_cnt, 0);
        chk("midrun_rst_cause", halt_cause, 0);

        // single step x3; a step_req during STEP is dropped
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1; tick(); step_req = 1'b0; settle();
            chk("step_state", state, 2);
            chk("step_cpu_en", cpu_en, 1);
            if (i == 0) step_req = 1'b1;
            tick(); step_req = 1'b0; settle();
            chk("step_done_state", state, 0);
            tick();
        end
        chk("step_ins", instr_cnt, 3);
        chk("step_cyc", cycle_cnt, 3);
        chk("step_cause", halt_cause, 3);

        // breakpoint and resume
        do_reset();
        bp_en = 1'b1; bp_addr = 64'h20; PCaddress = 64'h0;
        start_run();
        PCaddress = 64'h08; settle(); chk("bp_pc08", cpu_en, 1);
        tick(); PCaddress = 64'h10; settle(); chk("bp_pc10", cpu_en, 1);
        tick(); PCaddress = 64'h20; settle(); chk("bp_stop_en", cpu_en, 0);
        tick(); settle();
        chk("bp_state", state, 0);
        chk("bp_cause", halt_cause, 2);
        chk("bp_ins", instr_cnt, 2);
        start_run(); settle();
        chk("resume_commit", cpu_en, 1);
        tick(); PCaddress = 64'h28; settle(); chk("resume_next", cpu_en, 1);
        tick(); PCaddress = 64'h20; settle(); chk("bp_rearm_en", cpu_en, 0);
        tick(); settle();
        chk("bp_rearm_state", state, 0);
        chk("bp_rearm_cause", halt_cause, 2);

        // halt_req together with bp_hit -> cause 1
        start_run(); settle();
        chk("resume2_commit", cpu_en, 1);
        tick(); halt_req = 1'b1; settle();
        chk("halt_bp_en", cpu_en, 0);
        tick(); halt_req = 1'b0; settle();
        chk("halt_bp_cause", halt_cause, 1);
        chk("halt_bp_state", state, 0);

        // run_req and step_req together in IDLE -> RUN
        bp_en = 1'b0;
        run_req = 1'b1; step_req = 1'b1; tick(); run_req = 1'b0; step_req = 1'b0; settle();
        chk("run_step_prio", state, 1);

        // faults from RUN, terminal until reset
        for (int i = 0; i < 4; i++) begin
            do_reset();
            start_run();
            stat = f_stat[i]; settle();
            chk("fault_en", cpu_en, 0);
            tick(); stat = 3'd1; settle();
            chk("fault_state", state, 3);
            chk("fault_cause", halt_cause, f_exp[i]);
            run_req = 1'b1; step_req = 1'b1; tick(); run_req = 1'b0; step_req = 1'b0; settle();
            chk("fault_hold_state", state, 3);
            chk("fault_hold_cause", halt_cause, f_exp[i]);
            chk("fault_hold_en", cpu_en, 0);
        end

        // fault during STEP
        do_reset();
        step_req = 1'b1; tick(); step_req = 1'b0;
        stat = 3'd3; settle();
        chk("step_fault_en", cpu_en, 0);
        tick(); stat = 3'd1; settle();
        chk("step_fault_state", state, 3);
        chk("step_fault_cause", halt_cause, 5);
        chk("step_fault_ins", instr_cnt, 0);

        // counter wrap
        do_reset();
        start_run();
        repeat (20) tick();
        chk("wrap_cyc", cycle_cnt, 4);
        chk("wrap_ins", instr_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Run controller for the Y86-64 single-cycle core. It decides each cycle whether the datapath may commit architectural state: PC, register file, condition codes and data-memory write. It supports run, pause, single-step and a hardware breakpoint, and it stops permanently on any non-AOK status. It sits beside the top-level core, consumes the Stat unit's `stat` and the current `PCaddress`, and drives one commit enable `cpu_en` that gates every state element's update.

## Interface
- `CNT_W`, default 32: width of the cycle and instruction counters.
- `clk  in  1` — core clock; all state updates on its rising edge.
- `rst  in  1` — reset, synchronous, active-high.
- `stat  in  3` — status of the instruction being executed this cycle: 1=AOK, 2=HLT, 3=ADR, 4=INS; any other code is invalid.
- `PCaddress  in  64` — address of the instruction being executed this cycle.
- `run_req  in  1` — one-cycle pulse: start or continue free-running.
- `step_req  in  1` — one-cycle pulse: execute exactly one instruction.
- `halt_req  in  1` — one-cycle pulse: pause a free run.
- `bp_en  in  1` — breakpoint enable.
- `bp_addr  in  64` — breakpoint address.
- `cpu_en  out  1` — commit enable for PC, Regs, CC and Mem write. Combinational from the registered state and the current inputs.
- `state  out  2` — IDLE=0, RUN=1, STEP=2, FAULT=3.
- `halt_cause  out  3` — last stop reason:
  - 0 none, 1 halt_req, 2 breakpoint, 3 step done;
  - 4 HLT, 5 ADR, 6 INS, 7 invalid stat.
- `cycle_cnt  out  CNT_W` — cycles spent in RUN or STEP.
- `instr_cnt  out  CNT_W` — committed instructions, i.e. cycles with `cpu_en`=1.

## Operation
- `bp_hit` = `bp_en` && (`PCaddress` == `bp_addr`) && !`resume`.
  - `resume` is an internal flag, set on any entry into RUN.
  - `resume` clears after the first RUN cycle with `cpu_en`=1, and on leaving RUN.
- `fault` = (`stat` != 1).
- **IDLE**
  - `cpu_en`=0.
  - `run_req` → RUN; `halt_cause`←0; `resume`←1.
  - Otherwise `step_req` → STEP; `halt_cause`←0.
  - `run_req` has priority over `step_req`. `halt_req` is ignored.
- **RUN** (priority top-down)
  - `fault`: `cpu_en`=0 → FAULT; `halt_cause` set from `stat` (2→4, 3→5, 4→6, other→7).
  - `halt_req`: `cpu_en`=0 → IDLE; cause 1.
  - `bp_hit`: `cpu_en`=0 → IDLE; cause 2. The instruction at `bp_addr` is not executed.
  - Otherwise `cpu_en`=1; stay in RUN.
  - `run_req` and `step_req` are ignored in RUN.
- **STEP**
  - `fault`: `cpu_en`=0 → FAULT; cause from `stat` as in RUN.
  - Otherwise `cpu_en`=1 → IDLE; cause 3.
  - The breakpoint and all requests are ignored in STEP.
- **FAULT**
  - `cpu_en`=0; the state is terminal until `rst`.
  - All requests are ignored; `halt_cause` holds.
- A faulting instruction is never committed. PC stays on the `halt`/faulting instruction.
- Counters:
  - `cycle_cnt` += 1 each cycle `state` is RUN or STEP.
  - `instr_cnt` += 1 each cycle `cpu_en`=1.
  - Both wrap modulo 2^CNT_W; there is no overflow flag.

## Timing
- Reset (`rst`=1 at a rising edge) gives: `state`=IDLE, `resume`=0, `halt_cause`=0, `cycle_cnt`=0, `instr_cnt`=0, and therefore `cpu_en`=0.
- `rst` has priority over every other input, in every state including mid-RUN and FAULT.
- Request latency:
  - A request pulse sampled at edge N changes `state` after edge N.
  - The first commit for that request is the cycle after edge N, and the core's state updates at edge N+1.
- `halt_req`, `bp_hit` and `fault` take effect in the same cycle: `cpu_en` drops combinationally, and no commit happens at that edge.
- Step: exactly one commit per `step_req` accepted in IDLE.
- A `step_req` arriving while in STEP or RUN is dropped, not queued.
- Resume past a breakpoint:
  - `run_req` while stopped on `bp_addr` commits that instruction on the first RUN cycle.
  - The breakpoint re-arms from the next cycle onward.
- Simultaneous `halt_req` and `bp_hit` in RUN → cause 1.
- Simultaneous `fault` and anything else → FAULT.
- A counter at 2^CNT_W−1 that increments goes to 0.

## Test plan
- **Reset mid-RUN.** Reset, `run_req`, 10 AOK cycles, then assert `rst` → `instr_cnt`=0, `cycle_cnt`=0, `state`=0, `cpu_en`=0, `halt_cause`=0 on the cycle after the edge.
- **Breakpoint and resume.** `bp_en`=1, `bp_addr`=0x20; run a program reaching PC 0x20 → `cpu_en`=0 at PC 0x20, `state`=IDLE, `halt_cause`=2. Then `run_req` → one commit at 0x20, then RUN continues. When the PC returns to 0x20 later, it stops again.
- **Single step.** From IDLE, three `step_req` pulses spaced 3 cycles apart → exactly 3 commits, `instr_cnt`=3, `cycle_cnt`=3, `halt_cause`=3.
- **Faults.** RUN until `stat`=2 (HLT) → `cpu_en`=0 that cycle, `state`=3, `halt_cause`=4. Subsequent `run_req`/`step_req` → no change. Repeat with `stat`=3 → cause 5, `stat`=4 → cause 6, `stat`=0 → cause 7.
- **Request priorities.**
  - `halt_req` and `bp_hit` in the same RUN cycle → `halt_cause`=1, no commit.
  - `run_req` and `step_req` together in IDLE → RUN.
  - `halt_req` in IDLE → no effect.
- **Counter wrap.** With CNT_W=4, 20 RUN cycles with no stop → `cycle_cnt`=4 and `instr_cnt`=4 (wrapped from 15 to 0 at the 16th cycle).
